// File: rtl/pfs_regbank_arbiter.sv
// Shared register bank for the PFS bus: independent round-robin read and
// write arbitration over NSLV slaves, sequential clear sweep after reset,
// read-only version register, masked readback register and a self-clearing
// soft-reset control bit.
module pfs_regbank_arbiter #(
    parameter int NSLV           = 4,
    parameter int DWIDTH         = 16,
    parameter int NREGS          = 256,
    parameter int AWIDTH         = 8,
    parameter int VERSION        = 21,
    parameter int VERSION_ADDR   = 0,
    parameter int CONTROL_ADDR   = 1,
    parameter int SOFT_RESET_BIT = 0,
    parameter int SOFT_RESET_DUR = 4,
    parameter int MASK_ADDR      = 2,
    parameter int RD_MASK        = 'h7fff,
    parameter int CLEAR_ON_SOFT  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NSLV-1:0]          wr_req,
    input  logic [NSLV*AWIDTH-1:0]   wr_addr,
    input  logic [NSLV*DWIDTH-1:0]   wr_data,
    output logic [NSLV-1:0]          wr_gnt,
    input  logic [NSLV-1:0]          rd_req,
    input  logic [NSLV*AWIDTH-1:0]   rd_addr,
    output logic [NSLV-1:0]          rd_gnt,
    output logic [DWIDTH-1:0]        rd_data,
    output logic [NSLV-1:0]          rd_valid,
    output logic                     busy,
    output logic                     soft_reset
);

    localparam int PW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int SW = $clog2(SOFT_RESET_DUR + 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic [AWIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [DWIDTH-1:0] r_mem [NREGS];
    logic [SW-1:0]     r_sr_cnt;
    logic [DWIDTH-1:0] r_rd_data;
    logic [NSLV-1:0]   r_rd_valid;

    logic              w_run;
    logic [PW:0]       w_wr_pick, w_rd_pick;
    logic [PW-1:0]     w_wr_sel, w_rd_sel;
    logic              w_wr_en, w_rd_en;
    logic [AWIDTH-1:0] w_wr_addr, w_rd_addr;
    logic [DWIDTH-1:0] w_wr_data, w_wr_store, w_rd_val;
    logic              w_wr_is_ver, w_wr_is_ctl, w_sr_trig;

    // Returns {found, index} of the first requester at or after ptr, wrapping.
    function automatic logic [PW:0] f_rr_pick(input logic [NSLV-1:0] req,
                                              input logic [PW-1:0]   ptr);
        logic [PW:0]  pick;
        logic [31:0]  idx;
        pick = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            idx = i + {{(32-PW){1'b0}}, ptr};
            if (idx >= 32'(NSLV)) idx = idx - 32'(NSLV);
            if (!pick[PW] && req[idx[PW-1:0]]) pick = {1'b1, idx[PW-1:0]};
        end
        return pick;
    endfunction

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] sel);
        return (sel == PW'(NSLV - 1)) ? '0 : sel + 1'b1;
    endfunction

    assign w_run     = (r_state == S_RUN) && !reset;
    assign w_wr_pick = f_rr_pick(wr_req, r_wr_ptr);
    assign w_rd_pick = f_rr_pick(rd_req, r_rd_ptr);
    assign w_wr_en   = w_run && w_wr_pick[PW];
    assign w_rd_en   = w_run && w_rd_pick[PW];
    assign w_wr_sel  = w_wr_pick[PW-1:0];
    assign w_rd_sel  = w_rd_pick[PW-1:0];
    assign wr_gnt    = w_wr_en ? (NSLV'(1) << w_wr_sel) : '0;
    assign rd_gnt    = w_rd_en ? (NSLV'(1) << w_rd_sel) : '0;

    assign w_wr_addr   = wr_addr[w_wr_sel*AWIDTH +: AWIDTH];
    assign w_wr_data   = wr_data[w_wr_sel*DWIDTH +: DWIDTH];
    assign w_rd_addr   = rd_addr[w_rd_sel*AWIDTH +: AWIDTH];
    assign w_wr_is_ver = (w_wr_addr == AWIDTH'(VERSION_ADDR));
    assign w_wr_is_ctl = (w_wr_addr == AWIDTH'(CONTROL_ADDR));
    assign w_sr_trig   = w_wr_en && w_wr_is_ctl && w_wr_data[SOFT_RESET_BIT];
    assign w_wr_store  = w_wr_is_ctl ? (w_wr_data & ~(DWIDTH'(1) << SOFT_RESET_BIT))
                                     : w_wr_data;

    assign busy       = (r_state == S_CLEAR) || reset;
    assign soft_reset = (r_sr_cnt != '0) && !reset;
    assign rd_data    = r_rd_data;
    assign rd_valid   = r_rd_valid;

    // Read mux: version constant and masked register override the store.
    always_comb begin
        w_rd_val = r_mem[w_rd_addr];
        if (w_rd_addr == AWIDTH'(VERSION_ADDR))
            w_rd_val = DWIDTH'(VERSION);
        else if (w_rd_addr == AWIDTH'(MASK_ADDR))
            w_rd_val = r_mem[w_rd_addr] & DWIDTH'(RD_MASK);
    end

    // Next state: sweep NREGS addresses, then run until a soft-reset trigger.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == AWIDTH'(NREGS - 1)) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if ((CLEAR_ON_SOFT != 0) && w_sr_trig) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // State and sweep counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Round-robin pointers advance past the slave just granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= f_next(w_wr_sel);
            if (w_rd_en) r_rd_ptr <= f_next(w_rd_sel);
        end
    end

    // Register store: clear sweep or granted write; version writes dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == S_CLEAR)
                r_mem[r_cnt] <= '0;
            else if (w_wr_en && !w_wr_is_ver)
                r_mem[w_wr_addr] <= w_wr_store;
        end
    end

    // Registered read port; store reads the pre-write value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= rd_gnt;
            r_rd_data  <= w_rd_en ? w_rd_val : '0;
        end
    end

    // Soft-reset pulse counter; a retrigger reloads the full duration.
    always_ff @(posedge clock) begin
        if (reset)
            r_sr_cnt <= '0;
        else if (w_sr_trig)
            r_sr_cnt <= SW'(SOFT_RESET_DUR);
        else if (r_sr_cnt != '0)
            r_sr_cnt <= r_sr_cnt - 1'b1;
    end

endmodule

// File: tb/tb_pfs_regbank_arbiter.sv
// Bench for pfs_regbank_arbiter: vector table plus hand sequences for the
// clear sweep, fairness, soft reset and mid-sweep reset; reads are checked
// through a response queue.
module tb_pfs_regbank_arbiter;

    localparam int NSLV = 4;
    localparam int DW   = 16;
    localparam int AW   = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [NSLV-1:0]   wr_req;
    logic [NSLV*AW-1:0] wr_addr;
    logic [NSLV*DW-1:0] wr_data;
    logic [NSLV-1:0]   wr_gnt;
    logic [NSLV-1:0]   rd_req;
    logic [NSLV*AW-1:0] rd_addr;
    logic [NSLV-1:0]   rd_gnt;
    logic [DW-1:0]     rd_data;
    logic [NSLV-1:0]   rd_valid;
    logic              busy;
    logic              soft_reset;

    pfs_regbank_arbiter #(
        .NSLV(NSLV), .DWIDTH(DW), .NREGS(256), .AWIDTH(AW), .VERSION(21),
        .SOFT_RESET_DUR(4), .RD_MASK('h7fff), .CLEAR_ON_SOFT(1)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  wr_req;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic [3:0]  rd_req;
        logic [7:0]  raddr;
        logic [3:0]  exp_wr_gnt;
        logic [3:0]  exp_rd_gnt;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [3:0]  vld;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_en   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_read(input logic [3:0] vld, input logic [15:0] data);
        sb.push_back('{vld: vld, data: data});
    endtask

    // Non-requesting slaves get scrambled address/data so slice errors show.
    task automatic drive(input logic [3:0] wreq, input logic [7:0] waddr, input logic [15:0] wdata,
                         input logic [3:0] rreq, input logic [7:0] raddr);
        wr_req = wreq;
        rd_req = rreq;
        for (int k = 0; k < NSLV; k++) begin
            wr_addr[k*AW +: AW] = wreq[k] ? waddr : (waddr ^ 8'h5A ^ 8'(k));
            wr_data[k*DW +: DW] = wreq[k] ? wdata : ~wdata;
            rd_addr[k*AW +: AW] = rreq[k] ? raddr : (raddr ^ 8'hA5 ^ 8'(k));
        end
    endtask

    // Read response checker: pops one expectation per valid response.
    always @(negedge clock) begin
        if (chk_en) begin
            if (rd_valid !== 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("rd_unexpected_valid", {28'd0, rd_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rd_resp_valid", {28'd0, rd_valid}, {28'd0, e.vld});
                    chk("rd_resp_data", {16'd0, rd_data}, {16'd0, e.data});
                end
            end else begin
                chk("rd_idle_data", {16'd0, rd_data}, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   n;
        int   nsr;
        int   nb;
        int   gcnt[NSLV];
        logic [3:0] exp_w;
        logic [3:0] exp_r;

        vecs[0]  = '{4'b0100, 8'd9,   16'h1234, 4'b0010, 8'd9,   4'b0100, 4'b0010, 16'h0000};
        vecs[1]  = '{4'b0000, 8'd0,   16'h0000, 4'b0010, 8'd9,   4'b0000, 4'b0010, 16'h1234};
        vecs[2]  = '{4'b0001, 8'd2,   16'hffff, 4'b0000, 8'd0,   4'b0001, 4'b0000, 16'h0000};
        vecs[3]  = '{4'b0000, 8'd0,   16'h0000, 4'b1000, 8'd2,   4'b0000, 4'b1000, 16'h7fff};
        vecs[4]  = '{4'b0010, 8'd0,   16'hbeef, 4'b0001, 8'd0,   4'b0010, 4'b0001, 16'h0015};
        vecs[5]  = '{4'b0000, 8'd0,   16'h0000, 4'b0100, 8'd0,   4'b0000, 4'b0100, 16'h0015};
        vecs[6]  = '{4'b1000, 8'd255, 16'ha5a5, 4'b0001, 8'd255, 4'b1000, 4'b0001, 16'h0000};
        vecs[7]  = '{4'b0000, 8'd0,   16'h0000, 4'b0001, 8'd255, 4'b0000, 4'b0001, 16'ha5a5};
        vecs[8]  = '{4'b0001, 8'd1,   16'h00f0, 4'b0000, 8'd0,   4'b0001, 4'b0000, 16'h0000};
        vecs[9]  = '{4'b0000, 8'd0,   16'h0000, 4'b0100, 8'd1,   4'b0000, 4'b0100, 16'h00f0};
        vecs[10] = '{4'b0100, 8'd2,   16'h8001, 4'b0100, 8'd2,   4'b0100, 4'b0100, 16'h7fff};
        vecs[11] = '{4'b0000, 8'd0,   16'h0000, 4'b0010, 8'd2,   4'b0000, 4'b0010, 16'h0001};

        // Reset: slave 3 already asks to read addr 5; it must wait out the sweep.
        drive(4'b0000, 8'd0, 16'h0000, 4'b1000, 8'd5);
        reset = 1'b1;
        repeat (3) begin
            tick();
            #1;
            chk("reset_busy", {31'd0, busy}, 32'd1);
            chk("reset_wr_gnt", {28'd0, wr_gnt}, 32'd0);
            chk("reset_rd_gnt", {28'd0, rd_gnt}, 32'd0);
            chk("reset_rd_valid", {28'd0, rd_valid}, 32'd0);
            chk("reset_soft_reset", {31'd0, soft_reset}, 32'd0);
        end
        tick();
        reset = 1'b0;
        #1;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            chk("clear_no_rd_gnt", {28'd0, rd_gnt}, 32'd0);
            tick();
            #1;
        end
        chk("clear_busy_cycles", n, 256);
        chk("held_rd_gnt", {28'd0, rd_gnt}, 32'h8);
        expect_read(4'b1000, 16'h0000);
        tick();

        // Table-driven single-requester vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wr_req, vecs[i].waddr, vecs[i].wdata, vecs[i].rd_req, vecs[i].raddr);
            #1;
            chk($sformatf("vec%0d_wr_gnt", i), {28'd0, wr_gnt}, {28'd0, vecs[i].exp_wr_gnt});
            chk($sformatf("vec%0d_rd_gnt", i), {28'd0, rd_gnt}, {28'd0, vecs[i].exp_rd_gnt});
            chk($sformatf("vec%0d_soft_reset", i), {31'd0, soft_reset}, 32'd0);
            if (vecs[i].exp_rd_gnt != 4'b0000) expect_read(vecs[i].exp_rd_gnt, vecs[i].exp_rdata);
            tick();
        end

        // Fairness: all slaves request both ports; write pointer sits at 3, read at 2.
        wr_req = 4'b1111;
        rd_req = 4'b1111;
        for (int k = 0; k < NSLV; k++) begin
            wr_addr[k*AW +: AW] = 8'(20 + k);
            wr_data[k*DW +: DW] = 16'(16'h0100 * k + 16'h0011);
            rd_addr[k*AW +: AW] = 8'd9;
            gcnt[k] = 0;
        end
        for (int c = 0; c < 16; c++) begin
            #1;
            exp_w = 4'b0001 << ((3 + c) % 4);
            exp_r = 4'b0001 << ((2 + c) % 4);
            chk("rr_wr_gnt", {28'd0, wr_gnt}, {28'd0, exp_w});
            chk("rr_rd_gnt", {28'd0, rd_gnt}, {28'd0, exp_r});
            expect_read(exp_r, 16'h1234);
            for (int k = 0; k < NSLV; k++) if (wr_gnt[k]) gcnt[k]++;
            tick();
        end
        for (int k = 0; k < NSLV; k++) chk($sformatf("fair_cnt%0d", k), gcnt[k], 4);
        for (int k = 0; k < NSLV; k++) begin
            drive(4'b0000, 8'd0, 16'h0000, 4'(1 << k), 8'(20 + k));
            #1;
            chk("fair_rb_rd_gnt", {28'd0, rd_gnt}, 32'(1 << k));
            expect_read(4'(1 << k), 16'(16'h0100 * k + 16'h0011));
            tick();
        end

        // Soft reset: 4-cycle pulse and a 256-cycle re-clear starting together.
        drive(4'b0001, 8'd1, 16'h0001, 4'b0000, 8'd0);
        #1;
        chk("sr_trig_wr_gnt", {28'd0, wr_gnt}, 32'h1);
        tick();
        drive(4'b0000, 8'd0, 16'h0000, 4'b0000, 8'd0);
        #1;
        chk("sr_starts_high", {31'd0, soft_reset}, 32'd1);
        nsr = 0;
        nb  = 0;
        n   = 0;
        while ((busy || soft_reset) && n < 1000) begin
            n++;
            if (soft_reset) nsr++;
            if (busy) nb++;
            tick();
            #1;
        end
        chk("sr_pulse_cycles", nsr, 4);
        chk("sr_busy_cycles", nb, 256);
        tick();
        drive(4'b0000, 8'd0, 16'h0000, 4'b0100, 8'd1);
        #1;
        chk("sr_rb_ctl_gnt", {28'd0, rd_gnt}, 32'h4);
        expect_read(4'b0100, 16'h0000);
        tick();
        drive(4'b0000, 8'd0, 16'h0000, 4'b0001, 8'd9);
        #1;
        chk("sr_rb_a9_gnt", {28'd0, rd_gnt}, 32'h1);
        expect_read(4'b0001, 16'h0000);
        tick();
        drive(4'b0000, 8'd0, 16'h0000, 4'b0000, 8'd0);

        // Reset 100 cycles into a sweep restarts it from address 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (100) tick();
        chk("mid_sweep_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
            #1;
        end
        chk("restart_busy_cycles", n, 256);

        // Reset drops an active soft-reset pulse immediately.
        tick();
        drive(4'b0010, 8'd1, 16'h0001, 4'b0000, 8'd0);
        #1;
        chk("sr2_trig_wr_gnt", {28'd0, wr_gnt}, 32'h2);
        tick();
        drive(4'b0000, 8'd0, 16'h0000, 4'b0000, 8'd0);
        #1;
        chk("sr2_high", {31'd0, soft_reset}, 32'd1);
        reset = 1'b1;
        #1;
        chk("sr2_forced_low", {31'd0, soft_reset}, 32'd0);
        chk("sr2_reset_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("sr2_after_release", {31'd0, soft_reset}, 32'd0);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
            #1;
        end
        chk("sr2_busy_cycles", n, 256);

        tick();
        tick();
        tick();
        chk("scoreboard_drained", sb.size(), 0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
